// File: rtl/regfile_pkg.sv
// Register-file wide constants and types shared by the write-back and memory-port arbiters.
package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
    localparam logic [REG_DATA_W-1:0] REG_GP_RST = 32'h10008000;
    localparam logic [REG_DATA_W-1:0] REG_SP_RST = 32'h7FFFEFFC;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N, so ptr + k < 2N and a single subtraction wraps it.
            sum = {1'b0, ptr} + (IW+1)'(k);
            idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ write-back sources, each with a
// one-entry holding slot; round-robin grant, same-register writes kept in order.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    // valid/ready: a request transfers at a posedge where req_valid[i] & req_ready[i];
    // ready is computed from slot state and the other requests, never from this req_valid.
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         Write_register,
    output logic [DATA_W-1:0]         Write_Data,
    output logic [2:0]                grant_id,
    output logic [NUM_REGS-1:0]       pending_mask,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] slot_full_q, slot_full_d;
    logic [ADDR_W-1:0]  slot_addr_q [NUM_REQ];
    logic [ADDR_W-1:0]  slot_addr_d [NUM_REQ];
    logic [DATA_W-1:0]  slot_data_q [NUM_REQ];
    logic [DATA_W-1:0]  slot_data_d [NUM_REQ];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] ready_c;

    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr_arbiter (
        .req        (slot_full_q),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Write port: driven only from slot flops; suppressed during the reset cycle so held
    // writes are dropped rather than leaking out as the slots clear.
    always_comb begin
        RegWrite       = 1'b0;
        Write_register = '0;
        Write_Data     = '0;
        grant_id       = '0;
        if (gnt_any && !RESET) begin
            RegWrite       = 1'b1;
            Write_register = slot_addr_q[gnt_idx];
            Write_Data     = slot_data_q[gnt_idx];
            grant_id       = 3'(gnt_idx);
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (slot_full_q[i]) begin
                pending_mask[slot_addr_q[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign busy = |slot_full_q;

    // A request is held off while any other slot, or a lower-index request being accepted
    // this cycle, targets the same register: that is what preserves write-after-write order.
    always_comb begin
        logic collide;
        ready_c = '0;
        collide = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            collide = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j != i && slot_full_q[j] &&
                    slot_addr_q[j] == req_addr[i*ADDR_W +: ADDR_W]) begin
                    collide = 1'b1;
                end
                if (j < i && req_valid[j] && ready_c[j] &&
                    req_addr[j*ADDR_W +: ADDR_W] == req_addr[i*ADDR_W +: ADDR_W]) begin
                    collide = 1'b1;
                end
            end
            ready_c[i] = !RESET && (!slot_full_q[i] || gnt_onehot[i]) && !collide;
        end
    end

    assign req_ready = ready_c;

    // Grant drains first, then an accept refills, so a new request wins a slot being drained.
    always_comb begin
        slot_full_d = slot_full_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            slot_full_d[gnt_idx] = 1'b0;
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && ready_c[i]) begin
                // Writes to register 0 are consumed here and never occupy the slot.
                slot_full_d[i] = (req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
                slot_addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
                slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_full_q <= '0;
            rr_ptr_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model, a write scoreboard and a shadow register file.
module tb_regfile_wb_arbiter;

    localparam int N    = 3;
    localparam int SB_W = 55; // {seq[15:0], id[1:0], addr[4:0], data[31:0]}

    logic          CLK = 1'b0;
    logic          RESET;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic          RegWrite;
    logic [4:0]    Write_register;
    logic [31:0]   Write_Data;
    logic [2:0]    grant_id;
    logic [31:0]   pending_mask;
    logic          busy;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_Data     (Write_Data),
        .grant_id       (grant_id),
        .pending_mask   (pending_mask),
        .busy           (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;

    logic         d_rst;
    logic [N-1:0] d_valid;
    logic [4:0]   d_addr [N];
    logic [31:0]  d_data [N];

    bit           m_full [N];
    logic [4:0]   m_addr [N];
    logic [31:0]  m_data [N];
    int           m_ptr;

    logic [SB_W-1:0] exp_q[$];
    int              seq;
    int              last_seq [32];
    logic [31:0]     act_reg  [32];
    logic [2:0]      gid_log[$];

    logic [N-1:0] acc_last;
    logic [N-1:0] a_rdy;
    logic         a_wr;
    logic [2:0]   a_gid;
    logic [4:0]   a_waddr;
    logic [31:0]  a_wdata;
    logic [31:0]  a_mask;
    logic         a_busy;

    bit           pend [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver + reference model, one clock per call ----------------
    task automatic step();
        bit          e_any;
        int          e_idx;
        logic [N-1:0] e_rdy;
        logic [31:0] e_mask;
        bit          col;
        bit          wr;
        bit          found;
        int          idx;
        @(negedge CLK);
        RESET     = d_rst;
        req_valid = d_valid;
        for (int i = 0; i < N; i++) begin
            req_addr[i*5 +: 5]   = d_addr[i];
            req_data[i*32 +: 32] = d_data[i];
        end
        #1;
        e_any = 0;
        e_idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!e_any && m_full[idx]) begin
                e_any = 1;
                e_idx = idx;
            end
        end
        e_rdy = '0;
        for (int i = 0; i < N; i++) begin
            col = 0;
            for (int j = 0; j < N; j++) begin
                if (j != i && m_full[j] && m_addr[j] == d_addr[i]) col = 1;
                if (j < i && d_valid[j] && e_rdy[j] && d_addr[j] == d_addr[i]) col = 1;
            end
            e_rdy[i] = !d_rst && (!m_full[i] || (e_any && e_idx == i)) && !col;
        end
        e_mask = '0;
        for (int i = 0; i < N; i++) if (m_full[i]) e_mask = e_mask | (32'd1 << m_addr[i]);
        e_mask = e_mask & ~32'd1;
        wr = e_any && !d_rst;

        chk("req_ready", req_ready, e_rdy);
        chk("RegWrite", RegWrite, wr);
        chk("Write_register", Write_register, wr ? m_addr[e_idx] : 5'd0);
        chk("Write_Data", Write_Data, wr ? m_data[e_idx] : 32'd0);
        chk("grant_id", grant_id, wr ? e_idx : 0);
        chk("pending_mask", pending_mask, e_mask);
        chk("busy", busy, (m_full[0] || m_full[1] || m_full[2]));

        a_rdy   = req_ready;
        a_wr    = RegWrite;
        a_gid   = grant_id;
        a_waddr = Write_register;
        a_wdata = Write_Data;
        a_mask  = pending_mask;
        a_busy  = busy;

        @(posedge CLK);
        // scoreboard: every observed write must match an accepted request from that source
        if (a_wr) begin
            gid_log.push_back(a_gid);
            act_reg[a_waddr] = a_wdata;
            found = 0;
            for (int q = 0; q < exp_q.size(); q++) begin
                if (!found && {1'b0, exp_q[q][38:37]} == a_gid) begin
                    found = 1;
                    chk("sb_addr", a_waddr, exp_q[q][36:32]);
                    chk("sb_data", a_wdata, exp_q[q][31:0]);
                    chk("waw_order", int'(exp_q[q][54:39]) > last_seq[a_waddr], 1);
                    last_seq[a_waddr] = int'(exp_q[q][54:39]);
                    exp_q.delete(q);
                end
            end
            chk("sb_hit", found, 1);
        end
        acc_last = '0;
        if (d_rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_ptr = 0;
            exp_q.delete();
        end else begin
            if (e_any) begin
                m_full[e_idx] = 0;
                m_ptr = (e_idx + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (d_valid[i] && e_rdy[i]) begin
                    acc_last[i] = 1'b1;
                    if (d_addr[i] != 5'd0) begin
                        m_full[i] = 1;
                        m_addr[i] = d_addr[i];
                        m_data[i] = d_data[i];
                        exp_q.push_back({16'(seq), 2'(i), d_addr[i], d_data[i]});
                        seq++;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        d_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic burst(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        d_valid   = 3'b111;
        d_addr[0] = a0;
        d_addr[1] = a1;
        d_addr[2] = a2;
        for (int i = 0; i < N; i++) d_data[i] = $urandom;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got_acc;
        RESET     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        d_rst     = 1'b1;
        d_valid   = '0;
        m_ptr     = 0;
        seq       = 0;
        for (int i = 0; i < N; i++) begin
            d_addr[i] = '0; d_data[i] = '0;
            m_full[i] = 0;  m_addr[i] = '0; m_data[i] = '0;
            pend[i]   = 0;
        end
        for (int r = 0; r < 32; r++) begin
            act_reg[r]  = '0;
            last_seq[r] = -1;
        end

        // reset held two cycles with every requester valid
        d_valid   = 3'b111;
        d_addr[0] = 5'd1; d_addr[1] = 5'd2; d_addr[2] = 5'd3;
        step();
        step();
        chk("t1_ready_in_reset", a_rdy, 3'b000);
        chk("t1_mask_in_reset", a_mask, 32'd0);
        d_rst = 1'b0;
        step();
        chk("t1_ready_release", a_rdy, 3'b111);
        idle(4);

        // contention from rr_ptr=0, then again from rr_ptr=1
        gid_log.delete();
        burst(5'd9, 5'd10, 5'd11);
        idle(4);
        chk("t3_n_grants_a", gid_log.size(), 3);
        chk("t3_order_a", {gid_log[0], gid_log[1], gid_log[2]}, {3'd0, 3'd1, 3'd2});
        d_valid = 3'b001; d_addr[0] = 5'd13; d_data[0] = $urandom;
        step();
        idle(2);
        gid_log.delete();
        burst(5'd9, 5'd10, 5'd11);
        idle(4);
        chk("t3_n_grants_b", gid_log.size(), 3);
        chk("t3_order_b", {gid_log[0], gid_log[1], gid_log[2]}, {3'd1, 3'd2, 3'd0});

        // single write
        d_valid = 3'b010; d_addr[1] = 5'd8; d_data[1] = 32'hDEADBEEF;
        step();
        idle(1);
        chk("t2_regwrite", a_wr, 1'b1);
        chk("t2_waddr", a_waddr, 5'd8);
        chk("t2_gid", a_gid, 3'd1);
        chk("t2_mask", a_mask, 32'h100);
        chk("t2_reg8", act_reg[8], 32'hDEADBEEF);

        // write-after-write on register 12
        d_valid = 3'b101;
        d_addr[0] = 5'd12; d_data[0] = 32'd1;
        d_addr[2] = 5'd12; d_data[2] = 32'd2;
        step();
        chk("t4_req2_held", a_rdy[2], 1'b0);
        d_valid = 3'b100;
        got_acc = 0;
        for (int t = 0; t < 8 && !got_acc; t++) begin
            step();
            got_acc = acc_last[2];
        end
        chk("t4_req2_accepted", got_acc, 1'b1);
        idle(4);
        chk("t4_reg12", act_reg[12], 32'd2);

        // register zero
        d_valid = 3'b001; d_addr[0] = 5'd0; d_data[0] = 32'hFFFFFFFF;
        step();
        chk("t5_ready", a_rdy[0], 1'b1);
        idle(1);
        chk("t5_regwrite", a_wr, 1'b0);
        chk("t5_mask", a_mask, 32'd0);

        // reset with all slots full
        burst(5'd20, 5'd21, 5'd22);
        d_valid = '0;
        d_rst   = 1'b1;
        step();
        chk("t6_no_write_in_reset", a_wr, 1'b0);
        d_rst = 1'b0;
        step();
        chk("t6_busy_after", a_busy, 1'b0);
        idle(3);
        chk("t6_reg20", act_reg[20], 32'd0);
        chk("t6_reg21", act_reg[21], 32'd0);
        chk("t6_reg22", act_reg[22], 32'd0);

        // random traffic: requests held until accepted, small address range, rare resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1;
                    d_addr[i] = 5'($urandom_range(0, 7));
                    d_data[i] = $urandom;
                end
                d_valid[i] = pend[i];
            end
            d_rst = ($urandom_range(0, 99) == 0);
            step();
            for (int i = 0; i < N; i++) if (acc_last[i]) pend[i] = 0;
        end
        d_rst = 1'b0;
        idle(6);
        chk("sb_drained", exp_q.size(), 0);
        chk("idle_busy", a_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
